vga_pixel_fetch: RTL
====================

# vga_pixel_fetch

Pixel-stage consumer of the VGA sync generator in the Mandelbrot display path. On each pixel strobe it maps the generator's pixel_x/pixel_y to a framebuffer address and issues a one-clock read to the iteration-count framebuffer RAM. It then converts the returned iteration count to 12-bit RGB through a selectable palette with optional per-frame colour cycling, and delays hsync/vsync so they stay aligned with the colour output.

## Interface
- SCALE_SHIFT, 1, right-shift applied to pixel_x/pixel_y to form framebuffer coordinates (1 gives 320x240).
- FB_W, 320, framebuffer width in entries.
- FB_H, 240, framebuffer height in entries.
- ADDR_W, 17, framebuffer address width.
- ITER_W, 8, iteration-count width.
- ITER_MAX, 255, iteration value that marks a point inside the set.

Ports (name, direction, width, meaning):
- CLK_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_en  in  1  one-clock pixel strobe, at most one per 3 clocks (nominally 1 in 4).
- video_on  in  1  active-area flag from the sync generator.
- hsync, vsync  in  1 each  active-low syncs from the sync generator.
- pixel_x, pixel_y  in  10 each  current pixel coordinates.
- fb_addr  out  ADDR_W  framebuffer read address.
- fb_rd  out  1  read strobe.
- fb_data  in  ITER_W  RAM read data, valid on the clock after fb_rd is high.
- palette_sel  in  2  palette select.
- cycle_en  in  1  enables per-frame palette offset increment.
- rgb  out  12  {r[3:0], g[3:0], b[3:0]}.
- hsync_o, vsync_o  out  1 each  syncs delayed to match rgb.
- frame_done  out  1  one-clock pulse per frame.

## Operation
- Stage A, on a clock with pix_en=1:
  - fx = pixel_x >> SCALE_SHIFT; fy = pixel_y >> SCALE_SHIFT.
  - in_fb = video_on && fx < FB_W && fy < FB_H.
  - fb_addr <= fy*FB_W + fx, computed at full width and truncated to ADDR_W. fb_addr updates only when in_fb=1 and holds otherwise.
  - fb_rd <= in_fb for exactly that one clock, then 0.
  - Delay registers: von_d <= in_fb, hs_d <= hsync, vs_d <= vsync.
- Capture: on the clock after fb_rd=1, iter_r <= fb_data. iter_r holds when fb_rd=0.
- Stage B, on the next pix_en:
  - rgb <= von_d ? pal(iter_r) : 12'h000.
  - hsync_o <= hs_d; vsync_o <= vs_d.
- pal(i), with precedence: if i == ITER_MAX the result is 12'h000 for every palette. Otherwise, with j = (i + offset) mod 2^ITER_W:
  - sel 0: grayscale {i[7:4], i[7:4], i[7:4]}.
  - sel 1: r=i[3:0], g=i[5:2], b=i[7:4].
  - sel 2: same bit mapping as sel 1, applied to j.
  - sel 3: inverted grayscale {~i[7:4] x3}.
- Frame counter: a vsync 1->0 edge is detected on pix_en clocks by comparing vsync against the previous sampled value.
  - On an edge, frame_done pulses for one clock.
  - If cycle_en=1, offset (ITER_W bits) increments, wrapping 255->0. If cycle_en=0, offset holds.
- palette_sel and cycle_en are sampled live; a change takes effect at the next Stage B.

## Timing
- Latency: rgb, hsync_o and vsync_o reflect the inputs sampled two pix_en strobes earlier. All three are mutually aligned.
- fb_rd goes high 1 clock after the pix_en edge. fb_data is sampled 1 clock later. The 3-clock strobe spacing guarantees iter_r is settled before Stage B.
- Reset values: fb_addr=0, fb_rd=0, rgb=0, hsync_o=1, vsync_o=1, frame_done=0, offset=0, iter_r=0, von_d=0, hs_d=1, vs_d=1, previous-vsync register=1.
- Reset asserted mid-line: all registers return to reset values immediately. The first valid rgb appears on the 2nd pix_en after reset_n rises; no spurious frame_done is produced.
- pix_en=0: every register except iter_r capture holds; fb_rd stays 0.
- Out-of-range coordinates (fx>=FB_W or fy>=FB_H) while video_on=1: no read is issued and rgb=0.
- A frame edge coinciding with Stage B: Stage B uses the pre-increment offset; the new offset applies from the next strobe.

## Test plan
- Reset: hold reset_n=0 with random inputs -> rgb=0, fb_rd=0, hsync_o=1, vsync_o=1, frame_done=0; 2 strobes after release, outputs follow the inputs.
- Address: pixel_x=10, pixel_y=5, video_on=1, strobe -> fb_addr=645 and fb_rd high for exactly 1 clock. Then pixel_x=639, pixel_y=479 -> fb_addr=76799.
- Palette: sel 0, fb_data=8'hA7 -> rgb=12'hAAA on the 2nd strobe. sel 3, same data -> 12'h555. fb_data=8'hFF with any sel -> 12'h000.
- Blanking/sync: video_on=0 with hsync toggled -> fb_rd stays 0, rgb=0, and hsync_o follows hsync delayed by exactly 2 strobes.
- Cycling:
  - sel 2, cycle_en=1, 3 vsync falling edges -> 3 frame_done pulses, offset=3; fb_data=8'h10 -> rgb=12'h341.
  - Continue to 256 edges -> offset wraps to 0.
  - With cycle_en=0 -> offset holds.
- Mid-operation reset: assert reset_n=0 for 2 clocks mid-line after fb_rd -> outputs return to reset values at once; iter_r is not updated from the pending read.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Pixel-stage framebuffer fetch and palette lookup for the Mandelbrot VGA path.
// Two pix_en strobes of latency from pixel_x/pixel_y/syncs to rgb/hsync_o/vsync_o.
module vga_pixel_fetch #(
    parameter int SCALE_SHIFT = 1,
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int ADDR_W      = 17,
    parameter int ITER_W      = 8,
    parameter int ITER_MAX    = 255
) (
    input  logic              CLK_100MHz,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic              video_on,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    input  logic [ITER_W-1:0] fb_data,
    input  logic [1:0]        palette_sel,
    input  logic              cycle_en,
    output logic [11:0]       rgb,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              frame_done
);

    logic [31:0]       fx;
    logic [31:0]       fy;
    logic              in_fb;
    logic [ADDR_W-1:0] addr_calc;
    logic              frame_edge;

    logic [ITER_W-1:0] iter_reg;
    logic [ITER_W-1:0] offset_reg;
    logic              von_d_reg;
    logic              hs_d_reg;
    logic              vs_d_reg;
    logic              vsync_prev_reg;

    logic [ITER_W-1:0] pal_idx;
    logic [11:0]       pal_rgb;

    assign fx         = 32'(pixel_x) >> SCALE_SHIFT;
    assign fy         = 32'(pixel_y) >> SCALE_SHIFT;
    assign in_fb      = video_on && (fx < 32'(FB_W)) && (fy < 32'(FB_H));
    assign addr_calc  = ADDR_W'(fy * 32'(FB_W) + fx);
    assign frame_edge = vsync_prev_reg && !vsync;

    // Palettes index the top 8 bits of the iteration count; ITER_W is expected to be 8.
    always_comb begin
        pal_idx = iter_reg;
        pal_rgb = 12'h000;
        if (palette_sel == 2'd2) begin
            pal_idx = iter_reg + offset_reg;
        end
        if (iter_reg != ITER_W'(ITER_MAX)) begin
            case (palette_sel)
                2'd0:    pal_rgb = {3{pal_idx[7:4]}};
                2'd3:    pal_rgb = {3{~pal_idx[7:4]}};
                default: pal_rgb = {pal_idx[3:0], pal_idx[5:2], pal_idx[7:4]};
            endcase
        end
    end

    // Stage A: address, read strobe and the alignment delay line.
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            fb_addr   <= '0;
            fb_rd     <= 1'b0;
            von_d_reg <= 1'b0;
            hs_d_reg  <= 1'b1;
            vs_d_reg  <= 1'b1;
        end else begin
            fb_rd <= pix_en && in_fb;
            if (pix_en) begin
                von_d_reg <= in_fb;
                hs_d_reg  <= hsync;
                vs_d_reg  <= vsync;
                if (in_fb) begin
                    fb_addr <= addr_calc;
                end
            end
        end
    end

    // RAM data is valid the clock after fb_rd.
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            iter_reg <= '0;
        end else if (fb_rd) begin
            iter_reg <= fb_data;
        end
    end

    // Stage B: colour and delayed syncs.
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rgb     <= 12'h000;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else if (pix_en) begin
            rgb     <= von_d_reg ? pal_rgb : 12'h000;
            hsync_o <= hs_d_reg;
            vsync_o <= vs_d_reg;
        end
    end

    // Frame tracking; offset updates after Stage B has used the old value.
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev_reg <= 1'b1;
            frame_done     <= 1'b0;
            offset_reg     <= '0;
        end else begin
            frame_done <= pix_en && frame_edge;
            if (pix_en) begin
                vsync_prev_reg <= vsync;
                if (frame_edge && cycle_en) begin
                    offset_reg <= offset_reg + 1'b1;
                end
            end
        end
    end

endmodule
